// File: rtl/trace_uart_tx.sv
// trace_uart_tx: buffers (PC, write-data) pairs captured on a strobe and
// serializes each as a 9-byte UART 8N1 record for host-side trace capture.
module trace_uart_tx #(
    parameter int         CLKS_PER_BIT = 868,
    parameter int         FIFO_DEPTH   = 8,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         Capture,
    input  logic [31:0]                  PC_In,
    input  logic [31:0]                  WriteData_In,
    output logic                         Tx,
    output logic                         Busy,
    output logic                         Overflow,
    output logic [$clog2(FIFO_DEPTH):0]  FifoCount
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] BAUD_MAX   = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    logic [63:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    state_t        state;
    logic [3:0]    byte_idx;
    logic [2:0]    bit_idx;
    logic [BW-1:0] baud;
    logic          baud_end;
    logic [63:0]   rec;
    logic [7:0]    shift;
    logic          tx_q;

    // Byte n of the record: sync byte first, then PC and data MSB first.
    function automatic logic [7:0] rec_byte(
        input logic [63:0] r,
        input logic [3:0]  idx
    );
        logic [7:0] b;
        case (idx)
            4'd1:    b = r[63:56];
            4'd2:    b = r[55:48];
            4'd3:    b = r[47:40];
            4'd4:    b = r[39:32];
            4'd5:    b = r[31:24];
            4'd6:    b = r[23:16];
            4'd7:    b = r[15:8];
            4'd8:    b = r[7:0];
            default: b = SYNC_BYTE;
        endcase
        return b;
    endfunction

    // The full test uses the pre-edge count, so a same-edge pop never
    // makes room for a capture.
    assign full     = (count == FULL_COUNT);
    assign empty    = (count == '0);
    assign push     = Capture & ~full;
    assign pop      = (state == IDLE) & ~empty;
    assign baud_end = (baud == BAUD_MAX);

    assign Tx        = tx_q;
    assign Busy      = (state != IDLE) | ~empty;
    assign FifoCount = count;

    // FIFO storage; contents are don't-care while the pointers are reset.
    always_ff @(posedge Clk) begin
        if (push && !Reset) begin
            mem[wr_ptr] <= {PC_In, WriteData_In};
        end
    end

    // FIFO pointers, occupancy and the sticky drop flag.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            Overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (Capture && full) begin
                Overflow <= 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Serializer: frames each record byte as start, 8 data LSB first, stop.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            byte_idx <= '0;
            bit_idx  <= '0;
            baud     <= '0;
            rec      <= '0;
            shift    <= '0;
            tx_q     <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    tx_q <= 1'b1;
                    baud <= '0;
                    if (pop) begin
                        rec      <= mem[rd_ptr];
                        shift    <= SYNC_BYTE;
                        byte_idx <= '0;
                        tx_q     <= 1'b0;
                        state    <= START;
                    end
                end
                START: begin
                    if (baud_end) begin
                        baud    <= '0;
                        bit_idx <= '0;
                        tx_q    <= shift[0];
                        state   <= DATA;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud <= '0;
                        if (bit_idx == 3'd7) begin
                            tx_q  <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shift   <= shift >> 1;
                            tx_q    <= shift[1];
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_end) begin
                        baud <= '0;
                        if (byte_idx == 4'd8) begin
                            tx_q  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            byte_idx <= byte_idx + 4'd1;
                            shift    <= rec_byte(rec, byte_idx + 4'd1);
                            tx_q     <= 1'b0;
                            state    <= START;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                default: begin
                    tx_q  <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
